udp_rx: RTL and testbench
=========================

Name: udp_rx

Overview:
- GMII-side UDP/IPv4 frame receiver. It is the receive counterpart of the existing udp_tx.
- Consumes the byte stream from the PHY and strips preamble/SFD, Ethernet, IPv4 and UDP headers.
- Filters on destination MAC, IP and port. Delivers the payload as big-endian 32-bit words, then reports byte count and sender identity.
- FCS is not checked here; a separate CRC checker may run in parallel.

Parameters:
- BOARD_MAC, 48'h00_11_22_33_44_55, local MAC. Accepted along with broadcast ff_ff_ff_ff_ff_ff.
- BOARD_IP, {8'd192,8'd168,8'd1,8'd123}, local IPv4 address. The destination IP must equal it.
- BOARD_PORT, 16'd1234, local UDP port. The destination port must equal it.

Ports:
- clk  in  1  receive clock (GMII rx clock domain)
- reset  in  1  asynchronous, active-high reset
- gmii_rxd_valid  in  1  GMII receive data valid
- gmii_rxd_data  in  8  GMII receive byte
- rec_en  out  1  one-cycle strobe: rec_data holds a payload word
- rec_data  out  32  payload word; first byte received in [31:24]
- rec_pkt_done  out  1  one-cycle strobe: packet accepted and complete
- rec_byte_num  out  16  payload byte count (UDP length − 8); valid from rec_pkt_done until the next rec_pkt_done
- src_mac  out  48  sender MAC; same validity as rec_byte_num
- src_ip  out  32  sender IP; same validity
- src_port  out  16  sender UDP port; same validity

Behaviour:
- Reset: every output is 0, state is st_idle, all counters are 0.
- One-hot states: st_idle, st_preamble, st_eth_head, st_ip_head, st_udp_head, st_rx_data, st_rx_end.
- A byte is "sampled" on a clk edge where gmii_rxd_valid=1.
- st_idle:
  - Sampled 0x55 → st_preamble with the 0x55 count set to 1.
  - Any other byte → st_rx_end.
- st_preamble:
  - Sampled 0x55 increments the count.
  - Sampled 0xd5 with count==7 → st_eth_head.
  - Any other byte, a count above 7, or 0xd5 with count≠7 → st_rx_end.
- st_eth_head, 14 bytes:
  - Bytes 0-5: destination MAC.
  - Bytes 6-11: source MAC, captured into a shadow register.
  - Bytes 12-13: type.
  - Checked at byte 13: destination MAC must be BOARD_MAC or broadcast, and type must be 16'h0800. Pass → st_ip_head; fail → st_rx_end.
- st_ip_head, 20 bytes:
  - Byte 0 must be 8'h45. IHL≠5, i.e. IP options, is rejected.
  - Byte 9 must be 8'd17.
  - Bytes 12-15: source IP, captured into a shadow register.
  - Bytes 16-19 must equal BOARD_IP.
  - Checksum is not verified.
  - Failure is detected at the offending byte, or at byte 19 for the IP compare → st_rx_end. Pass → st_udp_head.
- st_udp_head, 8 bytes:
  - Bytes 0-1: source port, captured into the shadow register.
  - Bytes 2-3 must equal BOARD_PORT.
  - Bytes 4-5: UDP length L.
  - Bytes 6-7: checksum, ignored.
  - At byte 7: L<8 → st_rx_end; L==8 → zero-payload completion; otherwise → st_rx_data with the payload count N=L−8.
- st_rx_data:
  - Bytes are packed MSB-first into a 32-bit assembler.
  - After the 4th byte of a word is sampled, rec_data and rec_en=1 appear on the next cycle (latency 1).
  - After the N-th byte: a partial word (N mod 4 ≠ 0) is emitted with unused low bytes at 0.
  - On that same completion cycle: rec_pkt_done=1, rec_en=1 for the final word, and rec_byte_num, src_mac, src_ip and src_port are loaded from the shadows.
  - Then → st_rx_end.
- Zero-payload completion: rec_pkt_done=1 and rec_byte_num=0 one cycle after UDP byte 7. No rec_en. Then → st_rx_end.
- st_rx_end: bytes are ignored (Ethernet padding, FCS, rejected frames). Wait for gmii_rxd_valid=0, then → st_idle.
- gmii_rxd_valid=0 in any state other than st_idle or st_rx_end:
  - Abort to st_idle.
  - No rec_pkt_done and no further rec_en.
  - Published src_*/rec_byte_num are unchanged.
  - Already-emitted words are not retracted.
- Payload bytes beyond N: discarded. N larger than the bytes actually received: handled as an abort.
- rec_en and rec_pkt_done are registered single-cycle pulses. Back-to-back frames must work after ≥1 idle cycle (valid low).
- Asserting reset mid-frame: outputs clear immediately; the next frame is received normally after release.
- Widths: byte counters are 16 bits; L−8 is computed in 16 bits.

Test Plan:
- Unicast frame to BOARD_MAC/BOARD_IP/port 1234 from MAC 00_0a_35_01_02_03, IP 192.168.1.102, port 5000, 8-byte payload 01..08:
  - rec_en twice, data 32'h01020304 then 32'h05060708.
  - rec_pkt_done on the 2nd rec_en cycle, rec_byte_num=8, src_ip=32'hc0a80166, src_port=5000.
- Broadcast MAC, 5-byte payload aa bb cc dd ee followed by 13 pad bytes plus FCS:
  - Words 32'haabbccdd then 32'hee000000.
  - rec_byte_num=5.
  - Pad and FCS are ignored.
- Rejections: wrong destination MAC, type 16'h0806, protocol 6, destination IP 192.168.1.200, destination port 80, and UDP length 4.
  - Each gives no rec_en and no rec_pkt_done.
  - A following valid frame is received correctly.
- Preamble errors: 6×0x55 + 0xd5, and a byte 0x54 inside the preamble. Both are rejected.
- UDP length 8:
  - rec_pkt_done with rec_byte_num=0 and no rec_en.
  - gmii_rxd_valid dropped after 3 of 10 payload bytes: no rec_en, no rec_pkt_done, previous src_* retained.
- reset pulsed during st_ip_head:
  - All outputs 0 while reset is high.
  - Two back-to-back valid frames with 1 idle cycle between them both complete.

Source files
------------

// File: rtl/udp_rx_if.sv
// GMII receive input and UDP payload/result output bundle for udp_rx.
// slave is the receiver's view; master is the PHY/consumer side.
interface udp_rx_if;
    logic        gmii_rxd_valid;
    logic [7:0]  gmii_rxd_data;
    logic        rec_en;
    logic [31:0] rec_data;
    logic        rec_pkt_done;
    logic [15:0] rec_byte_num;
    logic [47:0] src_mac;
    logic [31:0] src_ip;
    logic [15:0] src_port;

    modport slave (
        input  gmii_rxd_valid, gmii_rxd_data,
        output rec_en, rec_data, rec_pkt_done, rec_byte_num,
               src_mac, src_ip, src_port
    );

    modport master (
        output gmii_rxd_valid, gmii_rxd_data,
        input  rec_en, rec_data, rec_pkt_done, rec_byte_num,
               src_mac, src_ip, src_port
    );
endinterface

// File: rtl/udp_rx.sv
// GMII UDP/IPv4 receiver: strips preamble and Ethernet/IPv4/UDP headers, filters
// on local MAC/IP/port and delivers the payload as big-endian 32-bit words.
module udp_rx #(
    parameter logic [47:0] BOARD_MAC  = 48'h00_11_22_33_44_55,
    parameter logic [31:0] BOARD_IP   = {8'd192, 8'd168, 8'd1, 8'd123},
    parameter logic [15:0] BOARD_PORT = 16'd1234
) (
    input  logic     clk,
    input  logic     reset,
    udp_rx_if.slave  bus
);

    typedef enum logic [6:0] {
        st_idle     = 7'b0000001,
        st_preamble = 7'b0000010,
        st_eth_head = 7'b0000100,
        st_ip_head  = 7'b0001000,
        st_udp_head = 7'b0010000,
        st_rx_data  = 7'b0100000,
        st_rx_end   = 7'b1000000
    } state_t;

    state_t      state;
    state_t      next_state;

    logic        valid;
    logic [7:0]  data;
    logic [15:0] cnt;
    logic [31:0] hdr_sh;
    logic [47:0] dst_mac_sh;
    logic [47:0] src_mac_sh;
    logic [31:0] src_ip_sh;
    logic [15:0] src_port_sh;
    logic [15:0] pay_num;
    logic [31:0] word;
    logic [31:0] word_next;
    logic        emit_word;
    logic        emit_last;
    logic        zero_done;
    logic        mac_ok;
    logic [15:0] udp_len;
    logic        in_header;

    assign valid     = bus.gmii_rxd_valid;
    assign data      = bus.gmii_rxd_data;
    assign mac_ok    = (dst_mac_sh == BOARD_MAC) || (dst_mac_sh == 48'hffff_ffff_ffff);
    // hdr_sh holds the last four header bytes, so at UDP byte 7 bytes 4-5 sit in [23:8]
    assign udp_len   = hdr_sh[23:8];
    assign in_header = (state == st_eth_head) || (state == st_ip_head) || (state == st_udp_head);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= st_idle;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        emit_word  = 1'b0;
        emit_last  = 1'b0;
        zero_done  = 1'b0;
        unique case (state)
            st_idle: begin
                if (valid) begin
                    next_state = (data == 8'h55) ? st_preamble : st_rx_end;
                end
            end
            st_preamble: begin
                if (!valid) begin
                    next_state = st_idle;
                end else if (data == 8'h55) begin
                    if (cnt >= 16'd7) begin
                        next_state = st_rx_end;
                    end
                end else if ((data == 8'hd5) && (cnt == 16'd7)) begin
                    next_state = st_eth_head;
                end else begin
                    next_state = st_rx_end;
                end
            end
            st_eth_head: begin
                if (!valid) begin
                    next_state = st_idle;
                end else if (cnt == 16'd13) begin
                    next_state = (mac_ok && ({hdr_sh[7:0], data} == 16'h0800))
                                 ? st_ip_head : st_rx_end;
                end
            end
            st_ip_head: begin
                if (!valid) begin
                    next_state = st_idle;
                end else if (((cnt == 16'd0) && (data != 8'h45)) ||
                             ((cnt == 16'd9) && (data != 8'd17))) begin
                    next_state = st_rx_end;
                end else if (cnt == 16'd19) begin
                    next_state = ({hdr_sh[23:0], data} == BOARD_IP) ? st_udp_head : st_rx_end;
                end
            end
            st_udp_head: begin
                if (!valid) begin
                    next_state = st_idle;
                end else if ((cnt == 16'd3) && ({hdr_sh[7:0], data} != BOARD_PORT)) begin
                    next_state = st_rx_end;
                end else if (cnt == 16'd7) begin
                    if (udp_len < 16'd8) begin
                        next_state = st_rx_end;
                    end else if (udp_len == 16'd8) begin
                        zero_done  = 1'b1;
                        next_state = st_rx_end;
                    end else begin
                        next_state = st_rx_data;
                    end
                end
            end
            st_rx_data: begin
                if (!valid) begin
                    next_state = st_idle;
                end else if (cnt == (pay_num - 16'd1)) begin
                    emit_word  = 1'b1;
                    emit_last  = 1'b1;
                    next_state = st_rx_end;
                end else if (cnt[1:0] == 2'd3) begin
                    emit_word = 1'b1;
                end
            end
            st_rx_end: begin
                if (!valid) begin
                    next_state = st_idle;
                end
            end
            default: next_state = st_idle;
        endcase
    end

    // A new word starts with zeroed low bytes, so a short final word comes out zero-padded
    always_comb begin
        word_next = word;
        unique case (cnt[1:0])
            2'd0: word_next = {data, 24'h0};
            2'd1: word_next = {word[31:24], data, 16'h0};
            2'd2: word_next = {word[31:16], data, 8'h0};
            2'd3: word_next = {word[31:8], data};
            default: word_next = word;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt              <= 16'd0;
            hdr_sh           <= 32'd0;
            dst_mac_sh       <= 48'd0;
            src_mac_sh       <= 48'd0;
            src_ip_sh        <= 32'd0;
            src_port_sh      <= 16'd0;
            pay_num          <= 16'd0;
            word             <= 32'd0;
            bus.rec_en       <= 1'b0;
            bus.rec_data     <= 32'd0;
            bus.rec_pkt_done <= 1'b0;
            bus.rec_byte_num <= 16'd0;
            bus.src_mac      <= 48'd0;
            bus.src_ip       <= 32'd0;
            bus.src_port     <= 16'd0;
        end else begin
            bus.rec_en       <= emit_word;
            bus.rec_pkt_done <= emit_last | zero_done;

            // Byte index restarts on every state change; the preamble count starts at one
            if (next_state != state) begin
                cnt <= (next_state == st_preamble) ? 16'd1 : 16'd0;
            end else if (valid) begin
                cnt <= cnt + 16'd1;
            end

            if (valid) begin
                if (in_header) begin
                    hdr_sh <= {hdr_sh[23:0], data};
                end
                if ((state == st_eth_head) && (cnt < 16'd6)) begin
                    dst_mac_sh <= {dst_mac_sh[39:0], data};
                end
                if ((state == st_eth_head) && (cnt >= 16'd6) && (cnt < 16'd12)) begin
                    src_mac_sh <= {src_mac_sh[39:0], data};
                end
                if ((state == st_ip_head) && (cnt >= 16'd12) && (cnt < 16'd16)) begin
                    src_ip_sh <= {src_ip_sh[23:0], data};
                end
                if ((state == st_udp_head) && (cnt < 16'd2)) begin
                    src_port_sh <= {src_port_sh[7:0], data};
                end
                if ((state == st_udp_head) && (cnt == 16'd7)) begin
                    pay_num <= udp_len - 16'd8;
                end
                if (state == st_rx_data) begin
                    word <= word_next;
                end
            end

            if (emit_word) begin
                bus.rec_data <= word_next;
            end
            if (emit_last || zero_done) begin
                bus.rec_byte_num <= zero_done ? 16'd0 : pay_num;
                bus.src_mac      <= src_mac_sh;
                bus.src_ip       <= src_ip_sh;
                bus.src_port     <= src_port_sh;
            end
        end
    end

endmodule

// File: tb/tb_udp_rx.sv
// Self-checking bench for udp_rx: directed and randomized frames checked against
// a field-level model of which frames are accepted and what they deliver.
module tb_udp_rx;

    localparam logic [47:0] BOARD_MAC  = 48'h00_11_22_33_44_55;
    localparam logic [31:0] BOARD_IP   = {8'd192, 8'd168, 8'd1, 8'd123};
    localparam logic [15:0] BOARD_PORT = 16'd1234;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    udp_rx_if bus ();

    udp_rx #(
        .BOARD_MAC  (BOARD_MAC),
        .BOARD_IP   (BOARD_IP),
        .BOARD_PORT (BOARD_PORT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int compared   = 0;
    int mismatched = 0;

    logic [31:0] got_words[$];
    logic [31:0] exp_words[$];
    int          done_cnt;
    int          exp_done;
    logic        done_en;
    logic        exp_done_en;
    logic [15:0] exp_byte_num;
    logic [47:0] exp_src_mac;
    logic [31:0] exp_src_ip;
    logic [15:0] exp_src_port;

    int          f_pre;
    int          f_bad_pos;
    logic [47:0] f_dst_mac;
    logic [47:0] f_src_mac;
    logic [15:0] f_type;
    logic [7:0]  f_ver;
    logic [7:0]  f_proto;
    logic [31:0] f_src_ip;
    logic [31:0] f_dst_ip;
    logic [15:0] f_src_port;
    logic [15:0] f_dst_port;
    logic [15:0] f_len;
    logic [7:0]  pay[$];
    logic [7:0]  tail[$];
    logic [7:0]  tx[$];

    // Output monitor, sampled away from the active edge
    always @(negedge clk) begin
        if (!reset) begin
            if (bus.rec_en) got_words.push_back(bus.rec_data);
            if (bus.rec_pkt_done) begin
                done_cnt = done_cnt + 1;
                done_en  = bus.rec_en;
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic apply_stimulus(input logic v, input logic [7:0] b);
        @(posedge clk);
        #1;
        bus.gmii_rxd_valid = v;
        bus.gmii_rxd_data  = b;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) apply_stimulus(1'b0, 8'h00);
    endtask

    task automatic clear_mon();
        got_words.delete();
        exp_words.delete();
        done_cnt = 0;
        exp_done = 0;
    endtask

    task automatic set_default(input int n);
        f_pre      = 7;
        f_bad_pos  = -1;
        f_dst_mac  = BOARD_MAC;
        f_src_mac  = {16'($urandom), $urandom};
        f_type     = 16'h0800;
        f_ver      = 8'h45;
        f_proto    = 8'd17;
        f_src_ip   = $urandom;
        f_dst_ip   = BOARD_IP;
        f_src_port = 16'($urandom);
        f_dst_port = BOARD_PORT;
        f_len      = 16'(n + 8);
        pay.delete();
        tail.delete();
        for (int i = 0; i < n; i++) pay.push_back(8'($urandom));
        for (int i = 0; i < int'($urandom_range(0, 4)); i++) tail.push_back(8'($urandom));
    endtask

    task automatic apply_fault(input int f);
        case (f)
            0: f_dst_mac = 48'h00_11_22_33_44_56;
            1: f_type = 16'h0806;
            2: f_proto = 8'd6;
            3: f_dst_ip = {8'd192, 8'd168, 8'd1, 8'd200};
            4: f_dst_port = 16'd80;
            5: f_len = 16'd4;
            6: begin
                int k;
                k = $urandom_range(0, pay.size() - 1);
                while (pay.size() > k) void'(pay.pop_back());
                tail.delete();
            end
            7: f_dst_mac = 48'hffff_ffff_ffff;
            8: begin
                f_len = 16'd8;
                pay.delete();
            end
            9: f_pre = 6;
            10: f_bad_pos = 2;
            default: ;
        endcase
    endtask

    task automatic build_tx();
        tx.delete();
        for (int i = 0; i < f_pre; i++) tx.push_back((i == f_bad_pos) ? 8'h54 : 8'h55);
        tx.push_back(8'hd5);
        for (int i = 5; i >= 0; i--) tx.push_back(f_dst_mac[8*i +: 8]);
        for (int i = 5; i >= 0; i--) tx.push_back(f_src_mac[8*i +: 8]);
        tx.push_back(f_type[15:8]);
        tx.push_back(f_type[7:0]);
        tx.push_back(f_ver);
        tx.push_back(8'h00);
        tx.push_back(8'(({16'd0, f_len} + 32'd20) >> 8));
        tx.push_back(8'(f_len + 16'd20));
        for (int i = 0; i < 4; i++) tx.push_back(8'($urandom));
        tx.push_back(8'd64);
        tx.push_back(f_proto);
        tx.push_back(8'($urandom));
        tx.push_back(8'($urandom));
        for (int i = 3; i >= 0; i--) tx.push_back(f_src_ip[8*i +: 8]);
        for (int i = 3; i >= 0; i--) tx.push_back(f_dst_ip[8*i +: 8]);
        tx.push_back(f_src_port[15:8]);
        tx.push_back(f_src_port[7:0]);
        tx.push_back(f_dst_port[15:8]);
        tx.push_back(f_dst_port[7:0]);
        tx.push_back(f_len[15:8]);
        tx.push_back(f_len[7:0]);
        tx.push_back(8'($urandom));
        tx.push_back(8'($urandom));
        foreach (pay[i]) tx.push_back(pay[i]);
        foreach (tail[i]) tx.push_back(tail[i]);
    endtask

    function automatic logic [31:0] word_at(input int w, input int n);
        logic [31:0] v;
        v = 32'd0;
        for (int b = 0; b < 4; b++)
            if (4*w + b < n) v[31-8*b -: 8] = pay[4*w + b];
        return v;
    endfunction

    task automatic publish(input logic [15:0] num);
        exp_done++;
        exp_byte_num = num;
        exp_src_mac  = f_src_mac;
        exp_src_ip   = f_src_ip;
        exp_src_port = f_src_port;
    endtask

    // Acceptance and delivery decided from the frame fields, not from the byte stream
    task automatic model_frame();
        logic ok;
        int   n;
        int   sent;
        ok = (f_pre == 7) && (f_bad_pos < 0) &&
             ((f_dst_mac == BOARD_MAC) || (f_dst_mac == 48'hffff_ffff_ffff)) &&
             (f_type == 16'h0800) && (f_ver == 8'h45) && (f_proto == 8'd17) &&
             (f_dst_ip == BOARD_IP) && (f_dst_port == BOARD_PORT) && (f_len >= 16'd8);
        if (ok) begin
            n    = int'(f_len) - 8;
            sent = pay.size();
            if (n == 0) begin
                exp_done_en = 1'b0;
                publish(16'd0);
            end else if (sent >= n) begin
                for (int w = 0; w < (n + 3) / 4; w++) exp_words.push_back(word_at(w, n));
                exp_done_en = 1'b1;
                publish(16'(n));
            end else begin
                for (int w = 0; w < sent / 4; w++) exp_words.push_back(word_at(w, n));
            end
        end
    endtask

    task automatic run_frame(input int idle_n);
        model_frame();
        build_tx();
        foreach (tx[i]) apply_stimulus(1'b1, tx[i]);
        idle(idle_n);
    endtask

    task automatic check_output(input string tag);
        logic [31:0] w;
        chk({tag, "_nwords"}, 64'(got_words.size()), 64'(exp_words.size()));
        for (int i = 0; i < exp_words.size(); i++) begin
            w = (i < got_words.size()) ? got_words[i] : 32'hxxxxxxxx;
            chk($sformatf("%s_word%0d", tag, i), 64'(w), 64'(exp_words[i]));
        end
        chk({tag, "_done"}, 64'(done_cnt), 64'(exp_done));
        if (exp_done > 0) chk({tag, "_done_en"}, 64'(done_en), 64'(exp_done_en));
        chk({tag, "_byte_num"}, 64'(bus.rec_byte_num), 64'(exp_byte_num));
        chk({tag, "_src_mac"}, 64'(bus.src_mac), 64'(exp_src_mac));
        chk({tag, "_src_ip"}, 64'(bus.src_ip), 64'(exp_src_ip));
        chk({tag, "_src_port"}, 64'(bus.src_port), 64'(exp_src_port));
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_rec_en"}, 64'(bus.rec_en), 64'd0);
        chk({tag, "_rec_data"}, 64'(bus.rec_data), 64'd0);
        chk({tag, "_pkt_done"}, 64'(bus.rec_pkt_done), 64'd0);
        chk({tag, "_byte_num"}, 64'(bus.rec_byte_num), 64'd0);
        chk({tag, "_src_mac"}, 64'(bus.src_mac), 64'd0);
        chk({tag, "_src_ip"}, 64'(bus.src_ip), 64'd0);
        chk({tag, "_src_port"}, 64'(bus.src_port), 64'd0);
    endtask

    initial begin
        reset              = 1'b1;
        bus.gmii_rxd_valid = 1'b0;
        bus.gmii_rxd_data  = 8'h00;
        exp_byte_num = 16'd0;
        exp_src_mac  = 48'd0;
        exp_src_ip   = 32'd0;
        exp_src_port = 16'd0;
        exp_done_en  = 1'b0;
        done_en      = 1'b0;
        clear_mon();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_zero("reset");
        @(posedge clk);
        #1 reset = 1'b0;
        idle(3);

        // Unicast, 8-byte payload 01..08
        clear_mon();
        set_default(8);
        pay.delete();
        for (int i = 1; i <= 8; i++) pay.push_back(8'(i));
        tail.delete();
        f_src_mac  = 48'h00_0a_35_01_02_03;
        f_src_ip   = {8'd192, 8'd168, 8'd1, 8'd102};
        f_src_port = 16'd5000;
        run_frame(3);
        check_output("unicast");
        chk("unicast_w0", 64'((got_words.size() > 0) ? got_words[0] : 32'hxxxxxxxx), 64'h01020304);
        chk("unicast_w1", 64'((got_words.size() > 1) ? got_words[1] : 32'hxxxxxxxx), 64'h05060708);
        chk("unicast_ip", 64'(bus.src_ip), 64'hc0a80166);

        // Broadcast, 5-byte payload with 13 pad bytes plus FCS
        clear_mon();
        set_default(5);
        pay.delete();
        pay.push_back(8'haa); pay.push_back(8'hbb); pay.push_back(8'hcc);
        pay.push_back(8'hdd); pay.push_back(8'hee);
        f_dst_mac = 48'hffff_ffff_ffff;
        tail.delete();
        for (int i = 0; i < 17; i++) tail.push_back(8'($urandom));
        run_frame(3);
        check_output("bcast");
        chk("bcast_w1", 64'((got_words.size() > 1) ? got_words[1] : 32'hxxxxxxxx), 64'hee000000);

        // Each rejection (and preamble error) followed by a good frame
        for (int f = 0; f <= 10; f++) begin
            if (f == 6 || f == 7 || f == 8) continue;
            clear_mon();
            set_default($urandom_range(1, 12));
            apply_fault(f);
            run_frame(2);
            set_default($urandom_range(1, 12));
            run_frame(2);
            check_output($sformatf("reject%0d", f));
        end

        // Zero-length payload
        clear_mon();
        set_default(0);
        apply_fault(8);
        run_frame(3);
        check_output("len8");

        // Valid dropped after 3 of 10 payload bytes
        clear_mon();
        set_default(10);
        while (pay.size() > 3) void'(pay.pop_back());
        tail.delete();
        run_frame(3);
        check_output("trunc");

        // Randomized frames with random faults
        for (int k = 0; k < 24; k++) begin
            clear_mon();
            set_default($urandom_range(1, 20));
            apply_fault($urandom_range(0, 14));
            run_frame($urandom_range(1, 3));
            check_output($sformatf("rand%0d", k));
        end

        // Reset pulsed inside the IP header, then two frames one idle cycle apart
        clear_mon();
        set_default(6);
        build_tx();
        for (int i = 0; i < 8 + 14 + 6; i++) apply_stimulus(1'b1, tx[i]);
        @(posedge clk);
        #1;
        reset = 1'b1;
        bus.gmii_rxd_valid = 1'b0;
        @(negedge clk);
        check_zero("rst_mid");
        exp_byte_num = 16'd0;
        exp_src_mac  = 48'd0;
        exp_src_ip   = 32'd0;
        exp_src_port = 16'd0;
        @(posedge clk);
        #1 reset = 1'b0;
        idle(1);
        set_default($urandom_range(1, 12));
        run_frame(1);
        set_default($urandom_range(1, 12));
        run_frame(3);
        check_output("b2b");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
